// File: rtl/cache_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ram_pkg
//  Description : Shared geometry constants and fill FSM encoding for the
//                cache data RAM sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_ram_pkg;

    localparam int CACHE_AW    = 9;
    localparam int CACHE_DW    = 16;
    localparam int CACHE_BURST = 4;
    localparam int CACHE_OW    = $clog2(CACHE_BURST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ram_sched
//  Description : Write-port arbiter (line fill vs CPU byte write) and
//                read-port sequencer with same-edge write bypass for the
//                512x16 byte-enable two-port cache data RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_ram_sched
    import cache_ram_pkg::*;
#(
    parameter  int AW    = CACHE_AW,
    parameter  int DW    = CACHE_DW,
    parameter  int BURST = CACHE_BURST,
    localparam int OW    = $clog2(BURST),
    localparam int BW    = DW / 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              fill_start,
    input  logic [AW-OW-1:0]  fill_line,
    input  logic [OW-1:0]     fill_crit,
    input  logic              fill_valid,
    input  logic [DW-1:0]     fill_data,
    output logic              fill_busy,
    output logic              fill_done,

    input  logic              cpu_wr_req,
    input  logic [AW-1:0]     cpu_wr_addr,
    input  logic [BW-1:0]     cpu_wr_be,
    input  logic [DW-1:0]     cpu_wr_data,
    output logic              cpu_wr_ack,

    input  logic              cpu_rd_req,
    input  logic [AW-1:0]     cpu_rd_addr,
    output logic              cpu_rd_valid,
    output logic [DW-1:0]     cpu_rd_data,

    output logic [AW-1:0]     ram_wraddress,
    output logic              ram_wren,
    output logic [BW-1:0]     ram_byteena,
    output logic [DW-1:0]     ram_data,
    output logic [AW-1:0]     ram_rdaddress,
    input  logic [DW-1:0]     ram_q
);

    fill_state_t         r_state;
    logic [AW-OW-1:0]    r_fill_line;
    logic [OW-1:0]       r_off;
    logic [OW-1:0]       r_cnt;
    logic                r_last_wr;

    logic                r_rd_pend;
    logic [BW-1:0]       r_byp_be;
    logic [DW-1:0]       r_byp_data;

    logic                w_fill_wr;
    logic                w_fill_lock;
    logic                w_wr_hit;
    logic                w_cpu_wr;
    logic                w_rd_hit;
    logic                w_rd_go;
    logic [DW-1:0]       w_rd_merged;

    // The line stays locked until its last word has actually landed in the RAM.
    assign w_fill_lock = (r_state == ST_FILL) || r_last_wr;
    assign w_fill_wr   = (r_state == ST_FILL) && fill_valid;

    assign w_wr_hit    = w_fill_lock && (cpu_wr_addr[AW-1:OW] == r_fill_line);
    assign w_cpu_wr    = cpu_wr_req && !cpu_wr_ack && !w_wr_hit && !w_fill_wr;

    assign w_rd_hit    = w_fill_lock && (cpu_rd_addr[AW-1:OW] == r_fill_line);
    assign w_rd_go     = cpu_rd_req && !r_rd_pend && !cpu_rd_valid && !w_rd_hit;

    assign fill_busy   = (r_state == ST_FILL);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fill_line   <= '0;
            r_off         <= '0;
            r_cnt         <= '0;
            r_last_wr     <= 1'b0;
            fill_done     <= 1'b0;
            cpu_wr_ack    <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_byteena   <= '0;
            ram_data      <= '0;
        end else begin
            ram_wren   <= 1'b0;
            cpu_wr_ack <= 1'b0;
            r_last_wr  <= 1'b0;
            fill_done  <= r_last_wr;

            case (r_state)
                ST_IDLE: begin
                    if (fill_start) begin
                        r_fill_line <= fill_line;
                        r_off       <= fill_crit;
                        r_cnt       <= '0;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        r_off <= r_off + OW'(1);
                        r_cnt <= r_cnt + OW'(1);
                        if (r_cnt == OW'(BURST - 1)) begin
                            r_state   <= ST_IDLE;
                            r_last_wr <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_fill_wr) begin
                ram_wren      <= 1'b1;
                ram_wraddress <= {r_fill_line, r_off};
                ram_byteena   <= '1;
                ram_data      <= fill_data;
            end else if (w_cpu_wr) begin
                ram_wren      <= 1'b1;
                ram_wraddress <= cpu_wr_addr;
                ram_byteena   <= cpu_wr_be;
                ram_data      <= cpu_wr_data;
                cpu_wr_ack    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_rdaddress <= '0;
            r_rd_pend     <= 1'b0;
            cpu_rd_valid  <= 1'b0;
            r_byp_be      <= '0;
            r_byp_data    <= '0;
        end else begin
            r_rd_pend    <= w_rd_go;
            cpu_rd_valid <= r_rd_pend;
            if (w_rd_go) begin
                ram_rdaddress <= cpu_rd_addr;
            end
            // A write landing on the read address at the RAM's read edge is
            // invisible in ram_q; keep its enabled bytes for the merge.
            if (r_rd_pend) begin
                r_byp_be   <= (ram_wren && (ram_wraddress == ram_rdaddress)) ? ram_byteena : '0;
                r_byp_data <= ram_data;
            end
        end
    end

    for (genvar g = 0; g < BW; g++) begin : g_lane
        assign w_rd_merged[8*g +: 8] = r_byp_be[g] ? r_byp_data[8*g +: 8] : ram_q[8*g +: 8];
    end

    assign cpu_rd_data = cpu_rd_valid ? w_rd_merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_ram_sched
//  Description : Directed self-checking bench for cache_ram_sched with a
//                behavioural old-data-on-collision RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_ram_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        fill_start;
    logic [6:0]  fill_line;
    logic [1:0]  fill_crit;
    logic        fill_valid;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        cpu_wr_req;
    logic [8:0]  cpu_wr_addr;
    logic [1:0]  cpu_wr_be;
    logic [15:0] cpu_wr_data;
    logic        cpu_wr_ack;
    logic        cpu_rd_req;
    logic [8:0]  cpu_rd_addr;
    logic        cpu_rd_valid;
    logic [15:0] cpu_rd_data;
    logic [8:0]  ram_wraddress;
    logic        ram_wren;
    logic [1:0]  ram_byteena;
    logic [15:0] ram_data;
    logic [8:0]  ram_rdaddress;
    logic [15:0] ram_q;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cache_ram_sched dut (
        .clock        (clock),
        .reset        (reset),
        .fill_start   (fill_start),
        .fill_line    (fill_line),
        .fill_crit    (fill_crit),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_be    (cpu_wr_be),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ack   (cpu_wr_ack),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_rd_addr  (cpu_rd_addr),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .ram_wraddress(ram_wraddress),
        .ram_wren     (ram_wren),
        .ram_byteena  (ram_byteena),
        .ram_data     (ram_data),
        .ram_rdaddress(ram_rdaddress),
        .ram_q        (ram_q)
    );

    // RAM model: registered read returning old data on a same-edge write.
    logic [15:0] mem [0:511];
    logic        mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_ready <= 1'b1;
        end else begin
            if (ram_wren) begin
                if (ram_byteena[0]) mem[ram_wraddress][7:0]  <= ram_data[7:0];
                if (ram_byteena[1]) mem[ram_wraddress][15:8] <= ram_data[15:8];
            end
        end
        ram_q <= mem[ram_rdaddress];
    end

    int          n_wr   = 0;
    int          n_done = 0;
    logic [8:0]  log_a  [0:255];
    logic [1:0]  log_be [0:255];
    logic [15:0] log_d  [0:255];
    always @(posedge clock) begin
        if (ram_wren === 1'b1 && n_wr < 256) begin
            log_a[n_wr]  = ram_wraddress;
            log_be[n_wr] = ram_byteena;
            log_d[n_wr]  = ram_data;
            n_wr++;
        end
        if (fill_done === 1'b1) n_done++;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", fill_busy); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", fill_done); end
        checks++; if (cpu_wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", cpu_wr_ack); end
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0h exp=0", cpu_rd_valid); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%0h exp=0", ram_wren); end
        checks++; if (ram_wraddress !== 9'd0) begin errors++; $display("FAIL reset_wraddr got=%0h exp=0", ram_wraddress); end
        checks++; if (ram_rdaddress !== 9'd0) begin errors++; $display("FAIL reset_rdaddr got=%0h exp=0", ram_rdaddress); end
        checks++; if (cpu_rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data got=%0h exp=0", cpu_rd_data); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fill();
        logic [8:0] exp_a [4];
        int base, dbase;
        exp_a = '{9'd22, 9'd23, 9'd20, 9'd21};
        base  = n_wr;
        dbase = n_done;
        fill_line = 7'd5; fill_crit = 2'd2; fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_start got=%0h exp=1", fill_busy); end
        for (int k = 0; k < 4; k++) begin
            fill_valid = 1'b1; fill_data = 16'hF000 + 16'(k);
            @(negedge clock);
        end
        fill_valid = 1'b0;
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end got=%0h exp=0", fill_busy); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_early got=%0h exp=0", fill_done); end
        @(negedge clock);
        checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL fill_done_pulse got=%0h exp=1", fill_done); end
        @(negedge clock);
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_drop got=%0h exp=0", fill_done); end
        repeat (2) @(negedge clock);
        checks++; if (n_wr - base !== 4) begin errors++; $display("FAIL fill_nwrites got=%0d exp=4", n_wr - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_a[base+k] !== exp_a[k] || log_be[base+k] !== 2'b11 || log_d[base+k] !== 16'hF000 + 16'(k)) begin
                errors++;
                $display("FAIL fill_word%0d got=a%0d/be%0b/%0h exp=a%0d/be11/%0h",
                         k, log_a[base+k], log_be[base+k], log_d[base+k], exp_a[k], 16'hF000 + 16'(k));
            end
        end
        checks++; if (n_done - dbase !== 1) begin errors++; $display("FAIL fill_done_count got=%0d exp=1", n_done - dbase); end
    endtask

    task automatic test_cpu_write();
        int base;
        base = n_wr;
        cpu_wr_addr = 9'h100; cpu_wr_be = 2'b01; cpu_wr_data = 16'hA5C3; cpu_wr_req = 1'b1;
        @(negedge clock);
        checks++; if (cpu_wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%0h exp=1", cpu_wr_ack); end
        checks++;
        if (ram_wren !== 1'b1 || ram_wraddress !== 9'h100 || ram_byteena !== 2'b01 || ram_data !== 16'hA5C3) begin
            errors++;
            $display("FAIL wr_port got=%0h/%0h/%0b/%0h exp=1/100/01/a5c3", ram_wren, ram_wraddress, ram_byteena, ram_data);
        end
        @(negedge clock);
        checks++; if (cpu_wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_repeat got=%0h exp=0", cpu_wr_ack); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_repeat got=%0h exp=0", ram_wren); end
        cpu_wr_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (n_wr - base !== 1) begin errors++; $display("FAIL wr_count got=%0d exp=1", n_wr - base); end
        checks++; if (mem[9'h100] !== 16'h11C3) begin errors++; $display("FAIL wr_bytelane got=%0h exp=11c3", mem[9'h100]); end
    endtask

    task automatic test_fill_and_write();
        logic [8:0] exp_a [5];
        int base;
        exp_a = '{9'h020, 9'h080, 9'h021, 9'h022, 9'h023};
        base  = n_wr;
        fill_line = 7'd8; fill_crit = 2'd0; fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        fill_valid = 1'b1; fill_data = 16'hE000;
        cpu_wr_req = 1'b1; cpu_wr_addr = 9'h080; cpu_wr_be = 2'b11; cpu_wr_data = 16'h1234;
        @(negedge clock);
        checks++;
        if (ram_wraddress !== 9'h020 || ram_data !== 16'hE000 || cpu_wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_fill_first got=%0h/%0h/ack%0h exp=20/e000/ack0", ram_wraddress, ram_data, cpu_wr_ack);
        end
        fill_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (ram_wren !== 1'b1 || ram_wraddress !== 9'h080 || ram_data !== 16'h1234 || cpu_wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL prio_cpu_next got=%0h/%0h/%0h/ack%0h exp=1/80/1234/ack1", ram_wren, ram_wraddress, ram_data, cpu_wr_ack);
        end
        cpu_wr_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            fill_valid = 1'b1; fill_data = 16'hE000 + 16'(k);
            @(negedge clock);
        end
        fill_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (n_wr - base !== 5) begin errors++; $display("FAIL prio_count got=%0d exp=5", n_wr - base); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (log_a[base+k] !== exp_a[k]) begin
                errors++; $display("FAIL prio_order%0d got=%0h exp=%0h", k, log_a[base+k], exp_a[k]);
            end
        end
    endtask

    task automatic test_bypass();
        cpu_wr_req = 1'b1; cpu_wr_addr = 9'h040; cpu_wr_be = 2'b10; cpu_wr_data = 16'hBEEF;
        cpu_rd_req = 1'b1; cpu_rd_addr = 9'h040;
        @(negedge clock);
        checks++; if (cpu_wr_ack !== 1'b1) begin errors++; $display("FAIL byp_ack got=%0h exp=1", cpu_wr_ack); end
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL byp_latency got=%0h exp=0", cpu_rd_valid); end
        cpu_wr_req = 1'b0;
        @(negedge clock);
        checks++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 16'hBE40) begin
            errors++; $display("FAIL byp_merge got=v%0h/%0h exp=v1/be40", cpu_rd_valid, cpu_rd_data);
        end
        cpu_rd_req = 1'b0;
        @(negedge clock);
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL byp_valid_drop got=%0h exp=0", cpu_rd_valid); end

        cpu_rd_req = 1'b1; cpu_rd_addr = 9'h040;
        @(negedge clock);
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_latency got=%0h exp=0", cpu_rd_valid); end
        @(negedge clock);
        checks++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 16'hBE40) begin
            errors++; $display("FAIL rd_plain got=v%0h/%0h exp=v1/be40", cpu_rd_valid, cpu_rd_data);
        end
        cpu_rd_addr = 9'h1FF;
        @(negedge clock);
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got=%0h exp=0", cpu_rd_valid); end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 16'h11FF) begin
            errors++; $display("FAIL rd_top_addr got=v%0h/%0h exp=v1/11ff", cpu_rd_valid, cpu_rd_data);
        end
        cpu_rd_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read_under_fill();
        int t_done, t_valid;
        logic [15:0] got;
        t_done = -1; t_valid = -1; got = '0;
        fill_line = 7'd9; fill_crit = 2'd3; fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        cpu_rd_req = 1'b1; cpu_rd_addr = 9'd37;
        for (int i = 0; i < 20; i++) begin
            if (fill_done === 1'b1 && t_done < 0) t_done = i;
            if (cpu_rd_valid === 1'b1 && t_valid < 0) begin
                t_valid = i; got = cpu_rd_data; cpu_rd_req = 1'b0;
            end
            fill_valid = (i < 4);
            fill_data  = 16'hD000 + 16'(i);
            @(negedge clock);
        end
        fill_valid = 1'b0;
        cpu_rd_req = 1'b0;
        checks++; if (t_done !== 5) begin errors++; $display("FAIL ruf_done_cycle got=%0d exp=5", t_done); end
        checks++; if (t_valid !== 7) begin errors++; $display("FAIL ruf_valid_cycle got=%0d exp=7", t_valid); end
        checks++; if (got !== 16'hD002) begin errors++; $display("FAIL ruf_data got=%0h exp=d002", got); end
    endtask

    task automatic test_reset_mid_fill();
        int dbase;
        dbase = n_done;
        fill_line = 7'd2; fill_crit = 2'd1; fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        fill_valid = 1'b1; fill_data = 16'hC000;
        @(negedge clock);
        fill_data = 16'hC001;
        cpu_rd_req = 1'b1; cpu_rd_addr = 9'h000;
        @(negedge clock);
        fill_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cpu_rd_req = 1'b0;
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", fill_busy); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", fill_done); end
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%0h exp=0", cpu_rd_valid); end
        fill_line = 7'd3; fill_crit = 2'd0; fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL rst_restart got=%0h exp=1", fill_busy); end
        checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_late got=%0h exp=0", cpu_rd_valid); end
        for (int k = 0; k < 4; k++) begin
            fill_valid = 1'b1; fill_data = 16'hB000 + 16'(k);
            @(negedge clock);
        end
        fill_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (n_done - dbase !== 1) begin errors++; $display("FAIL rst_done_count got=%0d exp=1", n_done - dbase); end
        checks++;
        if (mem[9] !== 16'hC000 || mem[10] !== 16'hC001 || mem[11] !== 16'h100B) begin
            errors++; $display("FAIL rst_partial got=%0h/%0h/%0h exp=c000/c001/100b", mem[9], mem[10], mem[11]);
        end
        checks++; if (mem[14] !== 16'hB002) begin errors++; $display("FAIL rst_newfill got=%0h exp=b002", mem[14]); end
    endtask

    initial begin
        reset = 1'b1;
        fill_start = 1'b0; fill_line = '0; fill_crit = '0; fill_valid = 1'b0; fill_data = '0;
        cpu_wr_req = 1'b0; cpu_wr_addr = '0; cpu_wr_be = '0; cpu_wr_data = '0;
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        test_reset();
        test_fill();
        test_cpu_write();
        test_fill_and_write();
        test_bypass();
        test_read_under_fill();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
